// File: rtl/dffre_bank_pkg.sv
// Shared types and helpers for the DFFRE register-bank write arbiter.
package dffre_bank_pkg;

  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned MAX_REGS = 16;

  // Result of a round-robin search over up to MAX_REQ requesters.
  typedef struct packed {
    logic               found;
    logic [2:0]         idx;
    logic [MAX_REQ-1:0] onehot;
  } rr_pick_t;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned b = 0; b < 32; b++) begin
      if ((32'd1 << b) < value) res = b + 1;
    end
    return res;
  endfunction

  // First set bit of elig, searching upward from ptr with wrap-around modulo num_req.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] elig,
                                       input logic [2:0]         ptr,
                                       input int unsigned        num_req);
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      j = {29'd0, ptr} + i;
      if (j >= num_req) j = j - num_req;
      if ((i < num_req) && !res.found && elig[j[2:0]]) begin
        res.found          = 1'b1;
        res.idx            = j[2:0];
        res.onehot[j[2:0]] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dffre_bank_rr_arb.sv
// Round-robin arbiter: rotating pointer plus registered one-hot grant pulse.
// The winner of the current search is also exported combinationally so the
// parent can capture that requester's address/data on the same edge.
module dffre_bank_rr_arb
  import dffre_bank_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PtrW   = clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               win_vld_o,
  output logic [PtrW-1:0]    win_idx_o
);

  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] elig;
  rr_pick_t           pick;
  logic               unused_onehot;

  // Search from the pointer; the requester granted this cycle is masked out.
  always_comb begin
    elig  = req_i & ~gnt_q;
    pick  = rr_pick(MAX_REQ'(elig), 3'(ptr_q), NUM_REQ);
    gnt_d = '0;
    ptr_d = ptr_q;
    if (pick.found) begin
      gnt_d = pick.onehot[NUM_REQ-1:0];
      ptr_d = (pick.idx == 3'(NUM_REQ - 1)) ? '0 : PtrW'(pick.idx + 3'd1);
    end
  end

  // Grant and pointer state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_q <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign win_vld_o     = pick.found;
  assign win_idx_o     = PtrW'(pick.idx);
  assign unused_onehot = ^pick.onehot;

endmodule

// File: rtl/dffre_bank_wr_arbiter.sv
// Round-robin write arbiter feeding a bank of enable-gated, reset-to-0 registers.
// Grant at edge k, bank write at edge k+1. Optional ACK output enabled by
// defining DFFRE_BANK_WR_ARBITER_ACK_EN.
module dffre_bank_wr_arbiter
  import dffre_bank_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                           C,
  input  logic                           R,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  WDATA,
  output logic [NUM_REQ-1:0]             GNT,
`ifdef DFFRE_BANK_WR_ARBITER_ACK_EN
  output logic [NUM_REQ-1:0]             ACK,
`endif
  output logic [NUM_REGS*DATA_WIDTH-1:0] Q
);

  localparam int unsigned PtrW = clog2(NUM_REQ);

  logic                  win_vld;
  logic [PtrW-1:0]       win_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  wr_vld_q, wr_vld_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0]   reg_en;

  dffre_bank_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i     (C),
    .rst_i     (R),
    .req_i     (REQ),
    .gnt_o     (GNT),
    .win_vld_o (win_vld),
    .win_idx_o (win_idx)
  );

  // Select the winning requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_idx == PtrW'(i)) begin
        sel_addr = ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = WDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next state of the write pipeline; address/data hold when idle.
  always_comb begin
    wr_vld_d  = win_vld;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (win_vld) begin
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
    end
  end

  // Write pipeline register; reset drops any in-flight write.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  for (genvar j = 0; j < int'(NUM_REGS); j++) begin : g_bank
    logic [DATA_WIDTH-1:0] reg_q;

    // Out-of-range addresses match no register, so such writes vanish.
    assign reg_en[j] = wr_vld_q && (wr_addr_q == ADDR_WIDTH'(j));

    // One DFFRE-style register: clock enable, reset to 0.
    always_ff @(posedge C or posedge R) begin
      if (R) begin
        reg_q <= '0;
      end else if (reg_en[j]) begin
        reg_q <= wr_data_q;
      end
    end

    assign Q[j*DATA_WIDTH +: DATA_WIDTH] = reg_q;
  end

`ifdef DFFRE_BANK_WR_ARBITER_ACK_EN
  logic [NUM_REQ-1:0] ack_q, ack_d;

  // GNT still holds the winner of the write now landing, so it identifies who to ack.
  always_comb begin
    ack_d = '0;
    if (|reg_en) ack_d = GNT;
  end

  // Acknowledge pulse, coincident with the bank update.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      ack_q <= '0;
    end else begin
      ack_q <= ack_d;
    end
  end

  assign ACK = ack_q;
`endif

endmodule

// File: tb/tb_dffre_bank_wr_arbiter.sv
// Directed bench for dffre_bank_wr_arbiter: a default instance (4 regs) and a
// 3-register instance for out-of-range writes. ACK checked when
// DFFRE_BANK_WR_ARBITER_ACK_EN is defined.
module tb_dffre_bank_wr_arbiter;

  logic        C = 1'b0;
  logic        R = 1'b1;
  logic [3:0]  req = '0, gnt;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0, q;
  logic [3:0]  req2 = '0, gnt2;
  logic [7:0]  addr2 = '0;
  logic [31:0] wdata2 = '0;
  logic [23:0] q2;
`ifdef DFFRE_BANK_WR_ARBITER_ACK_EN
  logic [3:0]  ack, ack2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 C = ~C;

  dffre_bank_wr_arbiter #(
    .NUM_REQ(4), .NUM_REGS(4), .DATA_WIDTH(8), .ADDR_WIDTH(2)
  ) dut (
    .C(C), .R(R), .REQ(req), .ADDR(addr), .WDATA(wdata), .GNT(gnt),
`ifdef DFFRE_BANK_WR_ARBITER_ACK_EN
    .ACK(ack),
`endif
    .Q(q)
  );

  dffre_bank_wr_arbiter #(
    .NUM_REQ(4), .NUM_REGS(3), .DATA_WIDTH(8), .ADDR_WIDTH(2)
  ) dut_oor (
    .C(C), .R(R), .REQ(req2), .ADDR(addr2), .WDATA(wdata2), .GNT(gnt2),
`ifdef DFFRE_BANK_WR_ARBITER_ACK_EN
    .ACK(ack2),
`endif
    .Q(q2)
  );

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic do_reset();
    R = 1'b1;
    req = '0; addr = '0; wdata = '0;
    req2 = '0; addr2 = '0; wdata2 = '0;
    step();
    step();
    R = 1'b0;
  endtask

  task automatic test_reset();
    R = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (gnt !== 4'b0000) begin
        n_fail++; $display("FAIL rst_gnt: got %b want 0000", gnt);
      end
      n_checks++;
      if (q !== 32'h0) begin
        n_fail++; $display("FAIL rst_q: got %h want 00000000", q);
      end
    end
    R = 1'b0;
    step();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++; $display("FAIL rst_first_gnt: got %b want 0001", gnt);
    end
    step();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++; $display("FAIL rst_ptr_after_first: got %b want 0010", gnt);
    end
    req = '0;
    step();
  endtask

  task automatic test_single_write();
    do_reset();
    req = 4'b0100;
    addr[5:4] = 2'd3;
    wdata[23:16] = 8'hA5;
    step();
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_fail++; $display("FAIL single_gnt: got %b want 0100", gnt);
    end
    n_checks++;
    if (q !== 32'h0) begin
      n_fail++; $display("FAIL single_q_early: got %h want 00000000", q);
    end
`ifdef DFFRE_BANK_WR_ARBITER_ACK_EN
    n_checks++;
    if (ack !== 4'b0000) begin
      n_fail++; $display("FAIL single_ack_early: got %b want 0000", ack);
    end
`endif
    req = '0;
    step();
    n_checks++;
    if (q !== 32'hA500_0000) begin
      n_fail++; $display("FAIL single_q: got %h want a5000000", q);
    end
    n_checks++;
    if (gnt !== 4'b0000) begin
      n_fail++; $display("FAIL single_gnt_pulse: got %b want 0000", gnt);
    end
`ifdef DFFRE_BANK_WR_ARBITER_ACK_EN
    n_checks++;
    if (ack !== 4'b0100) begin
      n_fail++; $display("FAIL single_ack: got %b want 0100", ack);
    end
    step();
    n_checks++;
    if (ack !== 4'b0000) begin
      n_fail++; $display("FAIL single_ack_pulse: got %b want 0000", ack);
    end
`endif
  endtask

  // Requester i writes 8'hD0+i to register 3-i.
  task automatic test_round_robin();
    logic [31:0] exp_q;
    logic [3:0]  exp_g;
    do_reset();
    req   = 4'b1111;
    addr  = {2'd0, 2'd1, 2'd2, 2'd3};
    wdata = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    exp_q = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_g = 4'b0001 << i;
      n_checks++;
      if (gnt !== exp_g) begin
        n_fail++; $display("FAIL rr_gnt%0d: got %b want %b", i, gnt, exp_g);
      end
      n_checks++;
      if (q !== exp_q) begin
        n_fail++; $display("FAIL rr_q%0d: got %h want %h", i, q, exp_q);
      end
      exp_q[(3-i)*8 +: 8] = 8'hD0 + 8'(i);
      req[i] = 1'b0;
    end
    step();
    n_checks++;
    if (q !== 32'hD0D1_D2D3) begin
      n_fail++; $display("FAIL rr_q_final: got %h want d0d1d2d3", q);
    end
  endtask

  task automatic test_same_reg();
    do_reset();
    req = 4'b0011;
    addr[1:0] = 2'd1; addr[3:2] = 2'd1;
    wdata[7:0] = 8'h11; wdata[15:8] = 8'h22;
    step();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++; $display("FAIL race_gnt0: got %b want 0001", gnt);
    end
    req[0] = 1'b0;
    step();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++; $display("FAIL race_gnt1: got %b want 0010", gnt);
    end
    n_checks++;
    if (q !== 32'h0000_1100) begin
      n_fail++; $display("FAIL race_q_mid: got %h want 00001100", q);
    end
    req[1] = 1'b0;
    step();
    n_checks++;
    if (q !== 32'h0000_2200) begin
      n_fail++; $display("FAIL race_q_final: got %h want 00002200", q);
    end
    n_checks++;
    if (gnt !== 4'b0000) begin
      n_fail++; $display("FAIL race_gnt_idle: got %b want 0000", gnt);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    req = 4'b0001;
    addr[1:0] = 2'd2;
    wdata[7:0] = 8'h5A;
    step();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++; $display("FAIL midrst_gnt: got %b want 0001", gnt);
    end
    R = 1'b1;
    #1;
    n_checks++;
    if (gnt !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_gnt_async: got %b want 0000", gnt);
    end
    step();
    n_checks++;
    if (q !== 32'h0) begin
      n_fail++; $display("FAIL midrst_q: got %h want 00000000", q);
    end
    req = 4'b0011;
    addr[3:2] = 2'd1;
    wdata[15:8] = 8'h77;
    R = 1'b0;
    step();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++; $display("FAIL midrst_restart: got %b want 0001", gnt);
    end
    req[0] = 1'b0;
    step();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++; $display("FAIL midrst_gnt1: got %b want 0010", gnt);
    end
    n_checks++;
    if (q !== 32'h005A_0000) begin
      n_fail++; $display("FAIL midrst_q_after: got %h want 005a0000", q);
    end
    req = '0;
    step();
    n_checks++;
    if (q !== 32'h005A_7700) begin
      n_fail++; $display("FAIL midrst_q_final: got %h want 005a7700", q);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    req2 = 4'b0001;
    addr2[1:0] = 2'd3;
    wdata2[7:0] = 8'hFF;
    step();
    n_checks++;
    if (gnt2 !== 4'b0001) begin
      n_fail++; $display("FAIL oor_gnt: got %b want 0001", gnt2);
    end
    req2 = '0;
    step();
    n_checks++;
    if (q2 !== 24'h0) begin
      n_fail++; $display("FAIL oor_q: got %h want 000000", q2);
    end
`ifdef DFFRE_BANK_WR_ARBITER_ACK_EN
    n_checks++;
    if (ack2 !== 4'b0000) begin
      n_fail++; $display("FAIL oor_ack: got %b want 0000", ack2);
    end
`endif
    req2 = 4'b0010;
    addr2[3:2] = 2'd2;
    wdata2[15:8] = 8'h3C;
    step();
    n_checks++;
    if (gnt2 !== 4'b0010) begin
      n_fail++; $display("FAIL oor_inrange_gnt: got %b want 0010", gnt2);
    end
    req2 = '0;
    step();
    n_checks++;
    if (q2 !== 24'h3C_0000) begin
      n_fail++; $display("FAIL oor_inrange_q: got %h want 3c0000", q2);
    end
`ifdef DFFRE_BANK_WR_ARBITER_ACK_EN
    n_checks++;
    if (ack2 !== 4'b0010) begin
      n_fail++; $display("FAIL oor_inrange_ack: got %b want 0010", ack2);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_same_reg();
    test_reset_mid_write();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dffre_bank_wr_arbiter.md
Name: dffre_bank_wr_arbiter

Overview:
Round-robin write arbiter and sequencer for a bank of enable-gated flip-flop registers built from DFFRE-style cells: D input, clock enable, reset to 0.
- Several requesters share the bank. One write is granted per cycle, and the winner's address and data are pipelined into the bank one edge later.
- Sits between configuration/control masters and the shared register bank in fabric-level primitive models.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_REGS, 4, number of registers in the bank (1..16)
DATA_WIDTH, 8, bits per register
ADDR_WIDTH, 2, register address width; must satisfy 2**ADDR_WIDTH >= NUM_REGS

Ports:
C  input  1  clock, posedge active
R  input  1  asynchronous reset, active-high
REQ  input  NUM_REQ  per-requester write request, level, held until granted
ADDR  input  NUM_REQ*ADDR_WIDTH  packed target address per requester, slice i = requester i
WDATA  input  NUM_REQ*DATA_WIDTH  packed write data per requester
GNT  output  NUM_REQ  registered one-hot grant, one-cycle pulse
Q  output  NUM_REGS*DATA_WIDTH  packed bank contents, slice j = register j

Behaviour:
- Reset (R=1, asynchronous, takes priority over everything):
  - GNT=0, Q=0, write-pipeline valid=0, round-robin pointer=0.
  - Reset asserted mid-operation drops any in-flight write. No partial update.
- Eligibility at each posedge C: elig = REQ & ~GNT.
  - Masking the requester granted in the current cycle prevents a double grant while that requester reacts.
- Arbitration on posedge C, when elig != 0:
  - Winner w is the first set bit of elig, searching from pointer upward with wrap-around modulo NUM_REQ.
  - GNT <= onehot(w). Pipeline register <= {valid=1, ADDR[w], WDATA[w]}. Pointer <= (w+1) mod NUM_REQ.
- Arbitration on posedge C, when elig == 0: GNT <= 0, valid <= 0, pointer unchanged.
- Write stage: on the posedge after the grant edge, if valid and addr < NUM_REGS, register[addr] <= data. All other registers hold (enable low).
  - Latency: REQ sampled at edge k → GNT high during cycle k..k+1 → Q updated at edge k+1.
- Requester handshake:
  - Requester i must hold REQ[i], ADDR and WDATA stable until it samples GNT[i]=1.
  - It may then drop REQ or present a new request in the same cycle. That new request is eligible at the next edge after GNT[i] falls.
- Throughput: one write per cycle across requesters. A single requester gets at most one grant every two cycles.
- Out-of-range address (addr >= NUM_REGS): grant issued normally, write silently dropped, Q unchanged.
- Simultaneous requests: strict round-robin. No requester waits more than NUM_REQ-1 grants.
- REQ dropped before grant: request is withdrawn, no write occurs. Legal.
- Back-to-back writes to the same register from different requesters: applied in grant order; last grant wins.
- No X propagation: all state registers are reset. Q powers up 0.

Optional Feature:
Macro DFFRE_BANK_WR_ARBITER_ACK_EN.
- Defined: adds output ACK [NUM_REQ]. ACK[w] pulses high for exactly one cycle at edge k+1, the same edge Q updates.
  - ACK asserts only for in-range writes. Out-of-range writes get GNT but no ACK.
  - ACK resets to 0.
- Undefined: port absent. No extra state.

Decomposition:
- Package dffre_bank_pkg holds:
  - Function clog2.
  - Function rr_pick(elig, ptr) returning one-hot winner plus index.
  - Localparam limits MAX_REQ=8, MAX_REGS=16.
- One sub-module, dffre_bank_rr_arb: pure round-robin pointer plus registered one-hot grant, parameterised by NUM_REQ.
- The top level owns the write pipeline and the enable-gated register bank.

Test Plan:
- Reset: hold R=1 with REQ=4'b1111 → GNT=0, Q=0 throughout. Release R → first grant GNT=4'b0001 one edge later, pointer then 1.
- Single write: requester 2 requests ADDR=3, WDATA=8'hA5 → GNT=4'b0100 next cycle, Q slice 3=8'hA5 one edge after that, other slices 0.
- Round-robin fairness: REQ=4'b1111 held continuously, each requester dropping REQ the cycle after its GNT → grant sequence 0001,0010,0100,1000. Four distinct writes land in grant order.
- Same-register race: req0 writes ADDR=1 8'h11 and req1 writes ADDR=1 8'h22, both requesting at the same edge → req0 granted first; final Q slice 1=8'h22.
- Reset mid-write: assert R in the cycle GNT is high → no register updated, Q=0, GNT=0. After release, arbitration restarts from requester 0.
- Out of range: NUM_REGS=3, ADDR=3, WDATA=8'hFF → GNT pulses, Q unchanged. With DFFRE_BANK_WR_ARBITER_ACK_EN defined, ACK stays 0.
